mau_sequencer: RTL and testbench

//  Command-driven controller for the matrix acceleration unit datapath (dual-port VRAM, two multiplier lanes, adder tree, accumulator).

---
 rtl/mau_pkg.sv | 22 ++
 rtl/mau_sequencer_if.sv | 35 +++
 rtl/mau_addr_gen.sv | 32 +++
 rtl/mau_sequencer.sv | 139 +++++++++++++
 tb/tb_mau_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared types and constants for the matrix acceleration unit sequencer.
// Imported by the interface, the address generator and the top.
package mau_pkg;

  localparam int MAU_AW    = 10;
  localparam int MAU_LEN_W = 10;
  localparam int MAU_STR_W = 4;

  typedef enum logic {
    MAU_DOT  = 1'b0,
    MAU_READ = 1'b1
  } mau_op_e;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    DONE
  } mau_state_e;

endpackage

// File: rtl/mau_sequencer_if.sv
// Command handshake bundle between host and sequencer.
// Host drives the command fields; sequencer returns cmd_ready.
interface mau_sequencer_if #(
  parameter int AW    = mau_pkg::MAU_AW,
  parameter int LEN_W = mau_pkg::MAU_LEN_W,
  parameter int STR_W = mau_pkg::MAU_STR_W
) ();
  import mau_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  mau_op_e          cmd_op;
  logic [AW-1:0]    cmd_base_a;
  logic [AW-1:0]    cmd_base_b;
  logic [STR_W-1:0] cmd_stride_a;
  logic [STR_W-1:0] cmd_stride_b;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op,
    output cmd_base_a, cmd_base_b,
    output cmd_stride_a, cmd_stride_b,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op,
    input  cmd_base_a, cmd_base_b,
    input  cmd_stride_a, cmd_stride_b,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/mau_addr_gen.sv
// Per-port VRAM address generator: load base and stride, then
// advance by stride on each step, wrapping mod 2^AW.
module mau_addr_gen
  import mau_pkg::*;
#(
  parameter int AW    = MAU_AW,
  parameter int STR_W = MAU_STR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    base,
  input  logic [STR_W-1:0] stride,
  input  logic             step,
  output logic [AW-1:0]    addr
);

  logic [STR_W-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr <= addr + AW'(stride_q);
    end
  end

endmodule

// File: rtl/mau_sequencer.sv
// MAU command sequencer: DOT (two-lane MAC) and READ (bus stream)
// over a dual-port VRAM with one-cycle read latency.
module mau_sequencer
  import mau_pkg::*;
#(
  parameter int AW    = MAU_AW,
  parameter int LEN_W = MAU_LEN_W,
  parameter int STR_W = MAU_STR_W
) (
  input  logic          clk,
  input  logic          reset,
  mau_sequencer_if.slave cmd,
  input  logic          x_valid,
  output logic          x_ready,
  output logic          cea,
  output logic          ceb,
  output logic [AW-1:0] ada,
  output logic [AW-1:0] adb,
  output logic          set_mults,
  output logic          acc_clr,
  output logic          set_acc,
  output logic          write_db,
  output logic          busy,
  output logic          done
);

  mau_state_e       state, state_n;
  mau_op_e          op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] consumed_q;
  logic             rd_valid_q;
  logic             set_acc_q;

  logic accept, issue, consume;
  logic last_issue, last_consume;
  logic is_read;

  assign is_read = (op_q == MAU_READ);
  assign accept  = (state == IDLE) && cmd.cmd_valid;

  // READ words leave on the bus unconditionally; DOT waits for the host
  assign consume = rd_valid_q && (is_read || x_valid);

  assign issue = ((state == CLEAR) || (state == RUN))
               && (issued_q != len_q)
               && (!rd_valid_q || consume);

  assign last_issue   = issue
                      && (issued_q == len_q - LEN_W'(1));
  assign last_consume = consume
                      && (consumed_q == len_q - LEN_W'(1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == MAU_DOT)
            state_n = CLEAR;
          else if (cmd.cmd_len == '0)
            state_n = DONE;
          else
            state_n = RUN;
        end
      end
      CLEAR: state_n = (len_q == '0) ? DONE : RUN;
      RUN: begin
        if (is_read ? last_issue : last_consume)
          state_n = FLUSH;
      end
      FLUSH: begin
        if (!rd_valid_q || consume)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= MAU_DOT;
      len_q      <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      rd_valid_q <= 1'b0;
      set_acc_q  <= 1'b0;
    end else begin
      state      <= state_n;
      set_acc_q  <= set_mults;
      rd_valid_q <= issue || (rd_valid_q && !consume);
      if (accept) begin
        op_q       <= cmd.cmd_op;
        len_q      <= cmd.cmd_len;
        issued_q   <= '0;
        consumed_q <= '0;
      end else begin
        if (issue)
          issued_q <= issued_q + LEN_W'(1);
        if (consume)
          consumed_q <= consumed_q + LEN_W'(1);
      end
    end
  end

  mau_addr_gen #(.AW(AW), .STR_W(STR_W)) u_gen_a (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .base   (cmd.cmd_base_a),
    .stride (cmd.cmd_stride_a),
    .step   (issue),
    .addr   (ada)
  );

  mau_addr_gen #(.AW(AW), .STR_W(STR_W)) u_gen_b (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .base   (cmd.cmd_base_b),
    .stride (cmd.cmd_stride_b),
    .step   (issue),
    .addr   (adb)
  );

  assign cmd.cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign cea       = issue;
  assign ceb       = issue;
  assign acc_clr   = (state == CLEAR);
  assign x_ready   = rd_valid_q && !is_read;
  assign set_mults = rd_valid_q && !is_read && x_valid;
  assign write_db  = rd_valid_q && is_read;
  assign set_acc   = set_acc_q;

endmodule

// File: tb/tb_mau_sequencer.sv
// Scoreboard bench for mau_sequencer: expected strobes and addresses
// are queued at command time and popped as the DUT raises them.
module tb_mau_sequencer;
  import mau_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mau_sequencer_if #(.AW(10), .LEN_W(10), .STR_W(4)) cmd ();

  logic       x_valid, x_ready;
  logic       cea, ceb;
  logic [9:0] ada, adb;
  logic       set_mults, acc_clr, set_acc;
  logic       write_db, busy, done;

  mau_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd.slave),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .cea       (cea),
    .ceb       (ceb),
    .ada       (ada),
    .adb       (adb),
    .set_mults (set_mults),
    .acc_clr   (acc_clr),
    .set_acc   (set_acc),
    .write_db  (write_db),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int         c;
    logic [9:0] a;
    logic [9:0] b;
  } ce_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  ce_t   q_ce[$];
  int    q_ev[5][$];
  ce_t   e;
  int    ec;
  logic [4:0] sv;
  string nm[5] = '{"acc_clr", "set_mults", "set_acc",
                   "write_db", "done"};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cea || ceb) begin
        checks++;
        if (q_ce.size() == 0) begin
          errors++;
          $display("FAIL ce_unexpected cyc=%0d ada=%h adb=%h",
                   cyc, ada, adb);
        end else begin
          e = q_ce.pop_front();
          if (cea !== 1'b1 || ceb !== 1'b1 || ada !== e.a ||
              adb !== e.b || cyc != e.c) begin
            errors++;
            $display("FAIL ce got cyc=%0d ada=%h adb=%h want cyc=%0d ada=%h adb=%h",
                     cyc, ada, adb, e.c, e.a, e.b);
          end
        end
      end
      sv = {done, write_db, set_acc, set_mults, acc_clr};
      for (int i = 0; i < 5; i++) begin
        if (sv[i]) begin
          checks++;
          if (q_ev[i].size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected cyc=%0d", nm[i], cyc);
          end else begin
            ec = q_ev[i].pop_front();
            if (cyc != ec) begin
              errors++;
              $display("FAIL %s got cyc=%0d want cyc=%0d",
                       nm[i], cyc, ec);
            end
          end
        end
      end
      if (write_db || set_mults) begin
        checks++;
        if (write_db && set_mults) begin
          errors++;
          $display("FAIL bus_conflict cyc=%0d got both want one", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge; accept lands on the next edge.
  task automatic send(input mau_op_e op,
                      input logic [9:0] ba, input logic [9:0] bb,
                      input logic [3:0] sa, input logic [3:0] sb,
                      input logic [9:0] n, output int t0);
    cmd.cmd_op       = op;
    cmd.cmd_base_a   = ba;
    cmd.cmd_base_b   = bb;
    cmd.cmd_stride_a = sa;
    cmd.cmd_stride_b = sb;
    cmd.cmd_len      = n;
    cmd.cmd_valid    = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    int t0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cea, ceb, set_mults, acc_clr, set_acc, write_db,
         busy, done, x_ready} !== 9'd0 || ada !== 10'd0 ||
        adb !== 10'd0 || cmd.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init got busy=%b ada=%h ready=%b want 0 0 1",
               busy, ada, cmd.cmd_ready);
    end
    tick();
    reset = 1'b1;
    send(MAU_DOT, 10'h050, 10'h060, 4'd1, 4'd1, 10'd8, t0);
    x_valid = 1'b1;
    tick();
    cmd.cmd_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_middot got busy=%b x_ready=%b want 1 1",
               busy, x_ready);
    end
    tick();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({cea, ceb, set_mults, acc_clr, set_acc, write_db,
         busy, done, x_ready} !== 9'd0 || ada !== 10'd0 ||
        adb !== 10'd0 || cmd.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got busy=%b set_acc=%b ada=%h ready=%b want 0 0 0 1",
               busy, set_acc, ada, cmd.cmd_ready);
    end
    tick();
    reset = 1'b1;
    x_valid = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_nodone got done=%b busy=%b want 0 0",
                 done, busy);
      end
      tick();
    end
  endtask

  task automatic test_dot();
    int t0;
    send(MAU_DOT, 10'h010, 10'h200, 4'd1, 4'd1, 10'd4, t0);
    q_ev[0].push_back(t0 + 1);
    for (int k = 0; k < 4; k++) begin
      q_ce.push_back('{t0 + k + 1, 10'(16 + k), 10'(512 + k)});
      q_ev[1].push_back(t0 + k + 2);
      q_ev[2].push_back(t0 + k + 3);
    end
    q_ev[4].push_back(t0 + 7);
    x_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) cmd.cmd_valid = 1'b0;
      @(negedge clk);
      if (k == 7) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL dot_done got %b want 1 at cycle 7", done);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || cmd.cmd_ready !== 1'b1 || q_ce.size() != 0) begin
      errors++;
      $display("FAIL dot_end got busy=%b ready=%b ce_left=%0d want 0 1 0",
               busy, cmd.cmd_ready, q_ce.size());
    end
    tick();
  endtask

  task automatic test_stall();
    int t0;
    send(MAU_DOT, 10'h010, 10'h200, 4'd1, 4'd2, 10'd3, t0);
    q_ev[0].push_back(t0 + 1);
    q_ce.push_back('{t0 + 1, 10'h010, 10'h200});
    q_ce.push_back('{t0 + 5, 10'h011, 10'h202});
    q_ce.push_back('{t0 + 6, 10'h012, 10'h204});
    for (int k = 5; k <= 7; k++) begin
      q_ev[1].push_back(t0 + k);
      q_ev[2].push_back(t0 + k + 1);
    end
    q_ev[4].push_back(t0 + 9);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) cmd.cmd_valid = 1'b0;
      x_valid = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        checks++;
        if (cea !== 1'b0 || ada !== 10'h011 || x_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall k=%0d got cea=%b ada=%h x_ready=%b want 0 011 1",
                   k, cea, ada, x_ready);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || q_ev[4].size() != 0) begin
      errors++;
      $display("FAIL stall_end got busy=%b done_left=%0d want 0 0",
               busy, q_ev[4].size());
    end
    tick();
  endtask

  task automatic test_read();
    int t0;
    send(MAU_READ, 10'h3FE, 10'h100, 4'd1, 4'd3, 10'd4, t0);
    for (int k = 0; k < 4; k++) begin
      q_ce.push_back('{t0 + k + 1, 10'(1022 + k), 10'(256 + 3 * k)});
      q_ev[3].push_back(t0 + k + 2);
    end
    q_ev[4].push_back(t0 + 6);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) cmd.cmd_valid = 1'b0;
      x_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if (ada !== 10'h000 || write_db !== 1'b1) begin
          errors++;
          $display("FAIL read_wrap got ada=%h write_db=%b want 000 1",
                   ada, write_db);
        end
      end
    end
    x_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || q_ce.size() != 0 || q_ev[3].size() != 0) begin
      errors++;
      $display("FAIL read_end got busy=%b ce_left=%0d wdb_left=%0d want 0 0 0",
               busy, q_ce.size(), q_ev[3].size());
    end
    tick();
  endtask

  task automatic test_len0();
    int t0;
    send(MAU_DOT, 10'h020, 10'h030, 4'd1, 4'd1, 10'd0, t0);
    q_ev[0].push_back(t0 + 1);
    q_ev[4].push_back(t0 + 2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        cmd.cmd_op     = MAU_READ;
        cmd.cmd_base_a = 10'h123;
        cmd.cmd_len    = 10'd5;
      end
      if (k == 3) cmd.cmd_valid = 1'b0;
      @(negedge clk);
      if (k <= 2) begin
        checks++;
        if (cmd.cmd_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_ignore k=%0d got ready=%b busy=%b want 0 1",
                   k, cmd.cmd_ready, busy);
        end
      end
    end
    tick();
    send(MAU_READ, 10'h040, 10'h040, 4'd1, 4'd1, 10'd0, t0);
    q_ev[4].push_back(t0 + 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) cmd.cmd_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || q_ev[4].size() != 0) begin
      errors++;
      $display("FAIL len0_end got busy=%b done_left=%0d want 0 0",
               busy, q_ev[4].size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t0;
    send(MAU_DOT, 10'h040, 10'h050, 4'd1, 4'd1, 10'd2, t0);
    q_ev[0].push_back(t0 + 1);
    q_ce.push_back('{t0 + 1, 10'h040, 10'h050});
    q_ce.push_back('{t0 + 2, 10'h041, 10'h051});
    q_ev[1].push_back(t0 + 2);
    q_ev[1].push_back(t0 + 3);
    q_ev[2].push_back(t0 + 3);
    q_ev[2].push_back(t0 + 4);
    q_ev[4].push_back(t0 + 5);
    q_ev[0].push_back(t0 + 7);
    q_ce.push_back('{t0 + 7, 10'h080, 10'h090});
    q_ev[1].push_back(t0 + 8);
    q_ev[2].push_back(t0 + 9);
    q_ev[4].push_back(t0 + 10);
    x_valid = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) begin
        cmd.cmd_base_a = 10'h080;
        cmd.cmd_base_b = 10'h090;
        cmd.cmd_len    = 10'd1;
      end
      if (k == 7) cmd.cmd_valid = 1'b0;
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (cmd.cmd_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready got ready=%b busy=%b want 1 0",
                   cmd.cmd_ready, busy);
        end
      end
      if (k == 7) begin
        checks++;
        if (acc_clr !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_clr got acc_clr=%b busy=%b want 1 1",
                   acc_clr, busy);
        end
      end
    end
    x_valid = 1'b0;
    tick();
  endtask

  initial begin
    cmd.cmd_valid    = 1'b0;
    cmd.cmd_op       = MAU_DOT;
    cmd.cmd_base_a   = '0;
    cmd.cmd_base_b   = '0;
    cmd.cmd_stride_a = '0;
    cmd.cmd_stride_b = '0;
    cmd.cmd_len      = '0;
    x_valid          = 1'b0;
    test_reset();
    test_dot();
    test_stall();
    test_read();
    test_len0();
    test_back_to_back();
    checks++;
    if (q_ce.size() != 0) begin
      errors++;
      $display("FAIL ce_leftover got %0d want 0", q_ce.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q_ev[i].size() != 0) begin
        errors++;
        $display("FAIL %s_leftover got %0d want 0", nm[i], q_ev[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
